// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM/UART memory arbiter.
// Used by mem_arbiter and its UART sequencer.
package mem_pkg;

    localparam int SRAM_ADDR_W = 18;

    localparam logic [15:0] UART_DATA_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_DEF = 16'hBF01;

    typedef enum logic [3:0] {
        IDLE,
        SRAM_RD,
        SRAM_WR,
        SRAM_WR_REL,
        UART_RD_WAIT,
        UART_RD,
        UART_WR,
        UART_WR_TBRE,
        UART_WR_TSRE,
        DONE
    } state_t;

endpackage

// File: rtl/uart_seq.sv
// UART read/write strobe sequencer.
// Started from the arbiter's IDLE decision; done is high in its final cycle.
module uart_seq
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_rd,
    input  logic        start_wr,
    input  logic [15:0] uart_rdata,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn,
    output logic        drive,
    output logic        done,
    output logic [15:0] rdata
);

    state_t state;
    logic   rd_cnt;
    logic   unused_hi;

    assign unused_hi = ^uart_rdata[15:8];
    assign rdata     = {8'b0, uart_rdata[7:0]};

    assign done = (state == UART_RD && rd_cnt)
               || (state == UART_WR_TSRE && tsre);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            rd_cnt <= 1'b0;
            rdn    <= 1'b1;
            wrn    <= 1'b1;
            drive  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_rd) begin
                        state <= UART_RD_WAIT;
                    end else if (start_wr) begin
                        state <= UART_WR;
                        wrn   <= 1'b0;
                        drive <= 1'b1;
                    end
                end
                UART_RD_WAIT: begin
                    if (data_ready) begin
                        state  <= UART_RD;
                        rdn    <= 1'b0;
                        rd_cnt <= 1'b0;
                    end
                end
                UART_RD: begin
                    if (rd_cnt) begin
                        state <= IDLE;
                        rdn   <= 1'b1;
                    end else begin
                        rd_cnt <= 1'b1;
                    end
                end
                UART_WR: begin
                    state <= UART_WR_TBRE;
                    wrn   <= 1'b1;
                    drive <= 1'b0;
                end
                UART_WR_TBRE: begin
                    if (tbre) state <= UART_WR_TSRE;
                end
                UART_WR_TSRE: begin
                    if (tsre) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and strobe sequencer for the shared SRAM and UART.
// Data requests win over fetches; UART sequences run in uart_seq.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int          WAIT_CYCLES    = 1,
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [15:0]            if_addr,
    output logic [15:0]            if_rdata,
    output logic                   if_ready,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [15:0]            mem_addr,
    input  logic [15:0]            mem_wdata,
    output logic [15:0]            mem_rdata,
    output logic                   mem_ready,
    output logic                   mem_conflict,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_wdata,
    input  logic [15:0]            sram_rdata,
    output logic                   sram_drive,
    output logic                   sram_en_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    input  logic [15:0]            uart_rdata,
    input  logic                   data_ready,
    input  logic                   tbre,
    input  logic                   tsre,
    output logic                   rdn,
    output logic                   wrn
);

    state_t      state;
    logic [1:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        fetch_q;
    logic        drive_q;

    logic        data_req;
    logic        hit_data;
    logic        hit_stat;
    logic        start_rd;
    logic        start_wr;
    logic        u_drive;
    logic        u_done;
    logic [15:0] u_rdata;

    assign data_req     = mem_read | mem_write;
    assign hit_data     = mem_addr == UART_DATA_ADDR;
    assign hit_stat     = mem_addr == UART_STAT_ADDR;
    assign start_rd     = (state == IDLE) & mem_read & hit_data;
    assign start_wr     = (state == IDLE) & mem_write & hit_data;
    assign mem_conflict = data_req & if_req;

    assign sram_addr  = {2'b00, addr_q};
    assign sram_wdata = wdata_q;
    assign sram_drive = drive_q | u_drive;

    uart_seq u_uart (
        .clk        (clk),
        .rst        (rst),
        .start_rd   (start_rd),
        .start_wr   (start_wr),
        .uart_rdata (uart_rdata),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rdn        (rdn),
        .wrn        (wrn),
        .drive      (u_drive),
        .done       (u_done),
        .rdata      (u_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            addr_q    <= 16'h0;
            wdata_q   <= 16'h0;
            fetch_q   <= 1'b0;
            drive_q   <= 1'b0;
            sram_en_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= 16'h0;
            mem_rdata <= 16'h0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= 2'(WAIT_CYCLES);
                    if (data_req) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        fetch_q <= 1'b0;
                        unique case (1'b1)
                            hit_data: begin
                                state <= mem_read ? UART_RD_WAIT : UART_WR;
                            end
                            hit_stat: begin
                                if (mem_read) begin
                                    mem_rdata <= {14'b0, data_ready, tbre & tsre};
                                end
                                mem_ready <= 1'b1;
                                state     <= DONE;
                            end
                            default: begin
                                sram_en_n <= 1'b0;
                                if (mem_read) begin
                                    sram_oe_n <= 1'b0;
                                    state     <= SRAM_RD;
                                end else begin
                                    sram_we_n <= 1'b0;
                                    drive_q   <= 1'b1;
                                    state     <= SRAM_WR;
                                end
                            end
                        endcase
                    end else if (if_req) begin
                        addr_q    <= if_addr;
                        fetch_q   <= 1'b1;
                        sram_en_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        state     <= SRAM_RD;
                    end
                end
                SRAM_RD: begin
                    if (cnt == 2'd0) begin
                        sram_en_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state     <= DONE;
                        if (fetch_q) begin
                            if_rdata <= sram_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            mem_rdata <= sram_rdata;
                            mem_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                SRAM_WR: begin
                    if (cnt == 2'd0) begin
                        sram_we_n <= 1'b1;
                        state     <= SRAM_WR_REL;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                SRAM_WR_REL: begin
                    sram_en_n <= 1'b1;
                    drive_q   <= 1'b0;
                    mem_ready <= 1'b1;
                    state     <= DONE;
                end
                // uart_seq owns the strobes; we only wait for its done
                UART_RD_WAIT, UART_WR: begin
                    if (u_done) begin
                        if (state == UART_RD_WAIT) mem_rdata <= u_rdata;
                        mem_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with WAIT_CYCLES=1.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] mem_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_conflict;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata = 16'h0;
    logic        sram_drive;
    logic        sram_en_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [15:0] uart_rdata = 16'h0;
    logic        data_ready = 1'b0;
    logic        tbre = 1'b0;
    logic        tsre = 1'b0;
    logic        rdn;
    logic        wrn;

    mem_arbiter #(
        .WAIT_CYCLES    (1),
        .UART_DATA_ADDR (16'hBF00),
        .UART_STAT_ADDR (16'hBF01)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_conflict (mem_conflict),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_drive   (sram_drive),
        .sram_en_n    (sram_en_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .uart_rdata   (uart_rdata),
        .data_ready   (data_ready),
        .tbre         (tbre),
        .tsre         (tsre),
        .rdn          (rdn),
        .wrn          (wrn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_fetch;
        logic [15:0] data;
        int          lat;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];

    int passed = 0;
    int total  = 0;

    int oe_low, we_low, rdn_low, wrn_low, rdn_first;
    logic [15:0] wd_seen;
    logic [17:0] addr_seen;
    logic        drv_seen;
    int tbre_at = -1;
    int tsre_at = -1;
    int dr_at   = -1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle the request is first presented in.
    task automatic run(input int budget, output int lat,
                       output bit got_if, output bit got_mem);
        lat = 1;
        got_if = 1'b0;
        got_mem = 1'b0;
        oe_low = 0; we_low = 0; rdn_low = 0; wrn_low = 0; rdn_first = 0;
        while (!got_if && !got_mem && lat < budget) begin
            tick();
            lat++;
            if (!sram_oe_n) begin
                oe_low++;
                addr_seen = sram_addr;
            end
            if (!sram_we_n) begin
                we_low++;
                wd_seen = sram_wdata;
                addr_seen = sram_addr;
                drv_seen = sram_drive;
            end
            if (!rdn) begin
                if (rdn_low == 0) rdn_first = lat;
                rdn_low++;
            end
            if (!wrn) begin
                wrn_low++;
                wd_seen = sram_wdata;
                drv_seen = sram_drive;
            end
            got_if = if_ready;
            got_mem = mem_ready;
            if (lat == tbre_at) tbre = 1'b1;
            if (lat == tsre_at) tsre = 1'b1;
            if (lat == dr_at) data_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({sram_en_n, sram_oe_n, sram_we_n, rdn, wrn} !== 5'b11111)
            $display("FAIL reset_strobes got %b want 11111",
                     {sram_en_n, sram_oe_n, sram_we_n, rdn, wrn});
        else passed++;
        total++;
        if ({sram_drive, if_ready, mem_ready, mem_conflict} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000",
                     {sram_drive, if_ready, mem_ready, mem_conflict});
        else passed++;
        total++;
        if ({if_rdata, mem_rdata, sram_wdata} !== 48'h0)
            $display("FAIL reset_data got %h want 0",
                     {if_rdata, mem_rdata, sram_wdata});
        else passed++;
        total++;
        if (sram_addr !== 18'h0)
            $display("FAIL reset_addr got %h want 0", sram_addr);
        else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        int lat;
        bit gi, gm;
        exp_t e;
        sram_rdata = 16'h6801;
        if_addr = 16'h0004;
        if_req = 1'b1;
        exp_q.push_back('{1'b1, 16'h6801, 4, 1'b1});
        run(30, lat, gi, gm);
        total++;
        if (gi !== 1'b1 || gm !== 1'b0)
            $display("FAIL fetch_route if/mem ready %b%b want 10", gi, gm);
        else passed++;
        if (gi || gm) begin
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat)
                $display("FAIL fetch_lat got %0d want %0d", lat, e.lat);
            else passed++;
            total++;
            if (if_rdata !== e.data)
                $display("FAIL fetch_data got %h want %h", if_rdata, e.data);
            else passed++;
            total++;
            if (oe_low !== 2)
                $display("FAIL fetch_oe_cycles got %0d want 2", oe_low);
            else passed++;
            total++;
            if (addr_seen !== 18'h00004)
                $display("FAIL fetch_addr got %h want 00004", addr_seen);
            else passed++;
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        int lat;
        bit gi, gm;
        exp_t e;
        sram_rdata = 16'h1234;
        if_addr = 16'h0010;
        if_req = 1'b1;
        mem_addr = 16'h8000;
        mem_wdata = 16'hABCD;
        mem_write = 1'b1;
        exp_q.push_back('{1'b0, 16'h0000, 5, 1'b0});
        exp_q.push_back('{1'b1, 16'h1234, 5, 1'b1});
        #1;
        total++;
        if (mem_conflict !== 1'b1)
            $display("FAIL conflict_raise got %b want 1", mem_conflict);
        else passed++;
        run(30, lat, gi, gm);
        total++;
        if (gi !== 1'b0 || gm !== 1'b1)
            $display("FAIL conflict_wr_route if/mem ready %b%b want 01", gi, gm);
        else passed++;
        if (gi || gm) begin
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat)
                $display("FAIL conflict_wr_lat got %0d want %0d", lat, e.lat);
            else passed++;
            total++;
            if (we_low !== 2 || wd_seen !== 16'hABCD || drv_seen !== 1'b1)
                $display("FAIL conflict_wr_strobe we=%0d wdata=%h drive=%b want 2 abcd 1",
                         we_low, wd_seen, drv_seen);
            else passed++;
            total++;
            if (addr_seen !== 18'h08000)
                $display("FAIL conflict_wr_addr got %h want 08000", addr_seen);
            else passed++;
        end
        total++;
        if (mem_conflict !== 1'b1)
            $display("FAIL conflict_hold got %b want 1", mem_conflict);
        else passed++;
        mem_write = 1'b0;
        #1;
        total++;
        if (mem_conflict !== 1'b0)
            $display("FAIL conflict_clear got %b want 0", mem_conflict);
        else passed++;
        run(30, lat, gi, gm);
        total++;
        if (gi !== 1'b1 || gm !== 1'b0)
            $display("FAIL conflict_if_route if/mem ready %b%b want 10", gi, gm);
        else passed++;
        if (gi || gm) begin
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat || if_rdata !== e.data)
                $display("FAIL conflict_if lat=%0d data=%h want %0d %h",
                         lat, if_rdata, e.lat, e.data);
            else passed++;
            total++;
            if (addr_seen !== 18'h00010)
                $display("FAIL conflict_if_addr got %h want 00010", addr_seen);
            else passed++;
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_uart_write();
        int lat;
        bit gi, gm;
        exp_t e;
        tbre = 1'b0;
        tsre = 1'b0;
        mem_addr = 16'hBF00;
        mem_wdata = 16'h0041;
        mem_write = 1'b1;
        tbre_at = 6;
        tsre_at = 9;
        exp_q.push_back('{1'b0, 16'h0000, 10, 1'b0});
        run(40, lat, gi, gm);
        total++;
        if (gm !== 1'b1 || gi !== 1'b0)
            $display("FAIL uwr_route if/mem ready %b%b want 01", gi, gm);
        else passed++;
        if (gi || gm) begin
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat)
                $display("FAIL uwr_lat got %0d want %0d", lat, e.lat);
            else passed++;
            total++;
            if (wrn_low !== 1 || wd_seen !== 16'h0041 || drv_seen !== 1'b1)
                $display("FAIL uwr_strobe wrn=%0d wdata=%h drive=%b want 1 0041 1",
                         wrn_low, wd_seen, drv_seen);
            else passed++;
            total++;
            if (we_low !== 0 || oe_low !== 0)
                $display("FAIL uwr_no_sram we=%0d oe=%0d want 0 0", we_low, oe_low);
            else passed++;
        end
        mem_write = 1'b0;
        tbre_at = -1;
        tsre_at = -1;
        tick();
    endtask

    task automatic test_status();
        int lat;
        bit gi, gm;
        exp_t e;
        logic [2:0] pats [4];
        logic [15:0] want;
        pats[0] = 3'b111;
        pats[1] = 3'b100;
        pats[2] = 3'b011;
        pats[3] = 3'b110;
        for (int i = 0; i < 4; i++) begin
            {data_ready, tbre, tsre} = pats[i];
            want = {14'b0, pats[i][2], pats[i][1] & pats[i][0]};
            mem_addr = 16'hBF01;
            mem_read = 1'b1;
            exp_q.push_back('{1'b0, want, 2, 1'b1});
            run(10, lat, gi, gm);
            total++;
            if (gm !== 1'b1)
                $display("FAIL stat_route[%0d] mem_ready %b want 1", i, gm);
            else passed++;
            if (gi || gm) begin
                e = exp_q.pop_front();
                total++;
                if (lat !== e.lat || mem_rdata !== e.data)
                    $display("FAIL stat_rd[%0d] lat=%0d data=%h want %0d %h",
                             i, lat, mem_rdata, e.lat, e.data);
                else passed++;
            end
            mem_read = 1'b0;
            tick();
        end
        mem_wdata = 16'hFFFF;
        mem_write = 1'b1;
        exp_q.push_back('{1'b0, 16'h0000, 2, 1'b0});
        run(10, lat, gi, gm);
        if (gi || gm) e = exp_q.pop_front();
        total++;
        if (gm !== 1'b1 || lat !== e.lat || wrn_low !== 0 || we_low !== 0)
            $display("FAIL stat_wr ready=%b lat=%0d wrn=%0d we=%0d want 1 2 0 0",
                     gm, lat, wrn_low, we_low);
        else passed++;
        mem_write = 1'b0;
        {data_ready, tbre, tsre} = 3'b000;
        tick();
    endtask

    task automatic test_uart_read();
        int lat;
        bit gi, gm;
        exp_t e;
        data_ready = 1'b0;
        uart_rdata = 16'hA55A;
        mem_addr = 16'hBF00;
        mem_read = 1'b1;
        dr_at = 11;
        exp_q.push_back('{1'b0, 16'h005A, 14, 1'b1});
        run(40, lat, gi, gm);
        total++;
        if (gm !== 1'b1 || gi !== 1'b0)
            $display("FAIL urd_route if/mem ready %b%b want 01", gi, gm);
        else passed++;
        if (gi || gm) begin
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat || mem_rdata !== e.data)
                $display("FAIL urd_result lat=%0d data=%h want %0d %h",
                         lat, mem_rdata, e.lat, e.data);
            else passed++;
            total++;
            if (rdn_low !== 2 || rdn_first !== 12)
                $display("FAIL urd_rdn low=%0d first=%0d want 2 12",
                         rdn_low, rdn_first);
            else passed++;
        end
        mem_read = 1'b0;
        data_ready = 1'b0;
        dr_at = -1;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        bit gi, gm;
        exp_t e;
        mem_addr = 16'h8002;
        mem_wdata = 16'h5555;
        mem_write = 1'b1;
        tick();
        total++;
        if (sram_we_n !== 1'b0 || sram_drive !== 1'b1)
            $display("FAIL rstmid_pre we_n=%b drive=%b want 0 1", sram_we_n, sram_drive);
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if ({sram_en_n, sram_oe_n, sram_we_n} !== 3'b111 || sram_drive !== 1'b0)
            $display("FAIL rstmid_release strobes=%b drive=%b want 111 0",
                     {sram_en_n, sram_oe_n, sram_we_n}, sram_drive);
        else passed++;
        rst = 1'b1;
        mem_write = 1'b0;
        pulses = (mem_ready || if_ready) ? 1 : 0;
        repeat (6) begin
            tick();
            if (mem_ready || if_ready || !sram_we_n) pulses++;
        end
        total++;
        if (pulses !== 0)
            $display("FAIL rstmid_quiet events=%0d want 0", pulses);
        else passed++;
        sram_rdata = 16'h0BEE;
        if_addr = 16'h0020;
        if_req = 1'b1;
        exp_q.push_back('{1'b1, 16'h0BEE, 4, 1'b1});
        run(30, lat, gi, gm);
        if (gi || gm) e = exp_q.pop_front();
        total++;
        if (gi !== 1'b1 || lat !== e.lat || if_rdata !== e.data)
            $display("FAIL rstmid_fetch ready=%b lat=%0d data=%h want 1 4 0bee",
                     gi, lat, if_rdata);
        else passed++;
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_uart_write();
        test_status();
        test_uart_read();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0)
            $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired want finish");
        $fatal(1, "watchdog");
    end

endmodule
